btn_conditioner: RTL and testbench

Multi-channel push-button/switch conditioner for the board-level inputs feeding the game/VGA control logic. Each channel is synchronised and debounced with its own counter, so channels settle independently. Each channel also produces registered press/release pulses and a long-press pulse. An optional auto-repeat pulse train supports held buttons (menu scrolling, continuous movement).

---
 rtl/btn_conditioner.sv | 83 ++++++++
 tb/tb_btn_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel sync + debounce with press, release and long-press pulses.
// Define BTN_REPEAT_EN to add the auto-repeat pulse train on rpt; otherwise rpt is tied low.
module btn_conditioner #(
  parameter int WIDTH = 4,
  parameter int N = 100000,
  parameter int LONG_N = 50000000,
  parameter int REPEAT_N = 10000000,
  parameter logic [WIDTH-1:0] INVERT = {WIDTH{1'b0}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] org,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long,
  output logic [WIDTH-1:0] rpt
);
  localparam int DW = $clog2(N);
  localparam int HW = $clog2(LONG_N + 1);
  logic [WIDTH-1:0] sync0_q, sync1_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= org ^ INVERT;
      sync1_q <= sync0_q;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic lvl_q, lvl_d, rise_q, fall_q, long_q, diff, done;
    always_comb begin
      diff = sync1_q[i] ^ lvl_q;
      done = diff && (dcnt_q == DW'(N - 1));
      dcnt_d = (diff && !done) ? dcnt_q + 1'b1 : '0;
      lvl_d = done ? sync1_q[i] : lvl_q;
      hcnt_d = !lvl_q ? '0 : (hcnt_q == HW'(LONG_N)) ? hcnt_q : hcnt_q + 1'b1;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        dcnt_q <= '0;
        hcnt_q <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
      end else begin
        dcnt_q <= dcnt_d;
        hcnt_q <= hcnt_d;
        lvl_q  <= lvl_d;
        rise_q <= lvl_d & ~lvl_q;
        fall_q <= ~lvl_d & lvl_q;
        long_q <= lvl_q && (hcnt_q == HW'(LONG_N - 1));
      end
    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign long[i]  = long_q;
`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_N);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic rpt_q, rep_on;
    // Repeat phase runs only once the hold counter has saturated and stops the cycle level drops.
    always_comb begin
      rep_on = lvl_d && lvl_q && (hcnt_q == HW'(LONG_N));
      rcnt_d = (!rep_on || rcnt_q == RW'(REPEAT_N - 1)) ? '0 : rcnt_q + 1'b1;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        rcnt_q <= '0;
        rpt_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rpt_q  <= rep_on && (rcnt_q == RW'(REPEAT_N - 1));
      end
    assign rpt[i] = rpt_q;
`else
    assign rpt[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table, directed and random checks of btn_conditioner against a window-based model.
module tb_btn_conditioner;
  localparam int WIDTH = 2;
  localparam int N = 4;
  localparam int LONG_N = 16;
  localparam int REPEAT_N = 8;
  localparam logic [1:0] INV = 2'b10;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [1:0] org = 2'b10;
  logic [1:0] level, rise, fall, long_p, rpt;
  int checks = 0;
  int passed = 0;
  btn_conditioner #(.WIDTH(WIDTH), .N(N), .LONG_N(LONG_N), .REPEAT_N(REPEAT_N), .INVERT(INV)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .org(org), .level(level),
    .rise(rise), .fall(fall), .long(long_p), .rpt(rpt)
  );
  always #5 sys_clk = ~sys_clk;
  logic [1:0] q[$];
  logic [1:0] m_lvl, e_rise, e_fall, e_long, e_rpt;
  int age[2];
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction
  function automatic void m_reset();
    q.delete();
    repeat (N + 2) q.push_back(2'b00);
    m_lvl = '0; e_rise = '0; e_fall = '0; e_long = '0; e_rpt = '0;
    age[0] = 0; age[1] = 0;
  endfunction
  // A level flips once the last N synchronised samples (two edges old) all disagree with it.
  function automatic void m_edge();
    logic [1:0] nl;
    logic flip;
    q.push_back(org ^ INV);
    if (q.size() > N + 2) void'(q.pop_front());
    for (int c = 0; c < 2; c++) begin
      flip = 1'b1;
      for (int k = 0; k < N; k++) if (q[k][c] == m_lvl[c]) flip = 1'b0;
      nl[c] = flip ? ~m_lvl[c] : m_lvl[c];
      if (m_lvl[c]) age[c]++;
      e_long[c] = m_lvl[c] && age[c] == LONG_N;
      e_rpt[c] = 1'b0;
`ifdef BTN_REPEAT_EN
      e_rpt[c] = m_lvl[c] && nl[c] && age[c] > LONG_N && ((age[c] - LONG_N) % REPEAT_N) == 0;
`endif
      e_rise[c] = nl[c] && !m_lvl[c];
      e_fall[c] = !nl[c] && m_lvl[c];
      if (e_rise[c]) age[c] = 0;
    end
    m_lvl = nl;
  endfunction
  task automatic tick(input logic [1:0] o);
    org = o;
    @(posedge sys_clk);
    m_edge();
    @(negedge sys_clk);
    check("model", {level, rise, fall, long_p, rpt}, {m_lvl, e_rise, e_fall, e_long, e_rpt});
  endtask
  typedef struct {
    logic [1:0] org;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;
  vec_t tbl[8];
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int r, r1, lng, nlng, rp, nrp, f, f1;
    logic [1:0] hv;
    int dur[2];
    for (int i = 0; i < 8; i++)
      tbl[i] = '{2'b11, (i >= 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b01 : 2'b00, 2'b00};
    m_reset();
    repeat (2) @(negedge sys_clk);
    check("reset", {level, rise, fall, long_p, rpt}, '0);
    sys_rst_n = 1'b1;
    repeat (50) tick(2'b10);
    check("idle", {level, rise, fall, long_p, rpt}, '0);
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].org);
      check("tbl", {level, rise, fall}, {tbl[i].lvl, tbl[i].rise, tbl[i].fall});
    end
    repeat (10) tick(2'b10);
    tick(2'b11); tick(2'b10); tick(2'b11); tick(2'b10);
    check("bounce_lvl", level, 2'b00);
    r = -1; lng = -1; nlng = 0; rp = -1; nrp = 0;
    for (int k = 0; k < 36; k++) begin
      tick(2'b11);
      if (rise[0] && r < 0) r = k;
      if (long_p[0]) begin nlng++; if (lng < 0) lng = k; end
      if (rpt[0]) begin nrp++; if (rp < 0) rp = k; end
    end
    check("bounce_rise", r, 5);
    check("long_off", lng - r, LONG_N);
    check("long_cnt", nlng, 1);
`ifdef BTN_REPEAT_EN
    check("rpt_off", rp - r, LONG_N + REPEAT_N);
    check("rpt_cnt", nrp, 1);
`else
    check("rpt_cnt", nrp, 0);
`endif
    f = -1;
    for (int k = 0; k < 12; k++) begin
      tick(2'b10);
      if (fall[0] && f < 0) f = k;
    end
    check("fall", f, 5);
    r = -1; r1 = -1;
    for (int k = 0; k < 10; k++) begin
      tick(2'b01);
      if (rise[0] && r < 0) r = k;
      if (rise[1] && r1 < 0) r1 = k;
    end
    check("simul_r0", r, 5);
    check("simul_r1", r1, 5);
    f = -1;
    for (int k = 0; k < 10; k++) begin
      tick(2'b00);
      if (fall[0] && f < 0) f = k;
    end
    check("indep_f0", f, 5);
    check("indep_l1", level, 2'b10);
    r = -1; f1 = -1;
    for (int k = 0; k < 10; k++) begin
      tick(2'b11);
      if (rise[0] && r < 0) r = k;
      if (fall[1] && f1 < 0) f1 = k;
    end
    check("swap_r0", r, 5);
    check("swap_f1", f1, 5);
    repeat (10) tick(2'b00);
    repeat (4) tick(2'b01);
    sys_rst_n = 1'b0;
    #1;
    check("rst_async", {level, rise, fall, long_p, rpt}, '0);
    m_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    r = -1; r1 = -1;
    for (int k = 0; k < 10; k++) begin
      tick(2'b01);
      if (rise[0] && r < 0) r = k;
      if (rise[1] && r1 < 0) r1 = k;
    end
    check("rst_rise0", r, 5);
    check("rst_rise1", r1, 5);
    hv = 2'b10; dur[0] = 0; dur[1] = 0;
    for (int k = 0; k < 1200; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (dur[c] == 0) begin
          hv[c] = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(4, 60);
        end
        dur[c]--;
      end
      if (k == 600) begin
        sys_rst_n = 1'b0;
        #1;
        check("rnd_rst", {level, rise, fall, long_p, rpt}, '0);
        m_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
      end
      tick(hv);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
